// File: rtl/libmemif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : libmemif                                                     |
// | Description : Shared MIG interface types and widths for the memory path.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package libmemif;

  localparam int MIG_ADDR_W = 31;
  localparam int MIG_DATA_W = 128;

  typedef enum logic [2:0] {
    MIG_CMD_WR = 3'b000,
    MIG_CMD_RD = 3'b001
  } mig_cmd_type;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WR1  = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mig_rdbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mig_rdbuf                                                    |
// | Description : FWFT read-return buffer with occupancy count.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mig_rdbuf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int                   c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]        c_DEPTH = DEPTH[c_AW:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW:0]     r_wr_ptr;
  logic [c_AW:0]     r_rd_ptr;
  logic              w_pop;
  logic              w_push;

  // Extra pointer bit distinguishes full from empty; count wraps naturally.
  assign count   = r_wr_ptr - r_rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == c_DEPTH);
  assign w_pop   = rd_en && !empty;
  assign w_push  = wr_en && (!full || w_pop);
  assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/mig_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mig_cmd_sequencer                                            |
// | Description : Turns address/write-data FIFO entries into MIG commands and  |
// |               buffers returned read data under a credit scheme.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mig_cmd_sequencer
  import libmemif::*;
#(
  parameter int ADDR_W    = MIG_ADDR_W,
  parameter int DATA_W    = MIG_DATA_W,
  parameter int RB_DEPTH  = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_done,
  input  logic                af_empty,
  input  logic [ADDR_W-1:0]   af_addr,
  input  logic                af_we,
  output logic                af_re,
  input  logic                wb_empty,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                wb_re,
  input  logic                app_af_afull,
  input  logic                app_wdf_afull,
  output logic                app_af_wren,
  output logic [2:0]          app_af_cmd,
  output logic [ADDR_W-1:0]   app_af_addr,
  output logic                app_wdf_wren,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask_data,
  input  logic                rd_data_valid,
  input  logic [DATA_W-1:0]   rd_data_fifo_out,
  input  logic                rb_re,
  output logic                rb_empty,
  output logic [DATA_W-1:0]   rb_data,
  output logic                rd_err
);

  localparam int                c_CNT_W  = $clog2(RB_DEPTH) + 1;
  localparam int                c_OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int                c_CRED_W = c_CNT_W + c_OUT_W + 2;
  localparam logic [c_OUT_W-1:0]  c_MAX_OUTST = c_OUT_W'(MAX_OUTST);
  localparam logic [c_CRED_W-1:0] c_RB_LIMIT  = c_CRED_W'(RB_DEPTH);

  seq_state_t          r_state;
  logic [c_OUT_W-1:0]  r_outst;
  logic                r_beat;

  logic [c_CNT_W-1:0]  w_rb_count;
  logic                w_rb_full;
  logic [c_CRED_W-1:0] w_cred_need;
  logic                w_issue_wr;
  logic                w_issue_rd;
  logic                w_wr_beat1;
  logic                w_rd_done;
  logic                w_overflow;
  logic                w_unexpected;

  // Reserve two beats per read in flight so the unstallable return path always fits.
  assign w_cred_need = c_CRED_W'(w_rb_count) + {c_CRED_W'(r_outst), 1'b0} + c_CRED_W'(2);

  assign w_issue_wr = (r_state == ST_IDLE) && !af_empty && af_we && !wb_empty &&
                      !app_af_afull && !app_wdf_afull;
  assign w_issue_rd = (r_state == ST_IDLE) && !af_empty && !af_we && !app_af_afull &&
                      (r_outst < c_MAX_OUTST) && (w_cred_need <= c_RB_LIMIT);
  assign w_wr_beat1 = (r_state == ST_WR1) && !wb_empty && !app_wdf_afull;

  assign af_re = w_issue_wr | w_issue_rd;
  assign wb_re = w_issue_wr | w_wr_beat1;

  assign w_rd_done    = rd_data_valid && r_beat && (r_outst != '0);
  assign w_overflow   = rd_data_valid && w_rb_full && !rb_re;
  assign w_unexpected = rd_data_valid && (r_outst == '0) && !r_beat;

  assign app_wdf_mask_data = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_outst      <= '0;
      r_beat       <= 1'b0;
      rd_err       <= 1'b0;
      app_af_wren  <= 1'b0;
      app_af_cmd   <= 3'b000;
      app_af_addr  <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_data <= '0;
    end else begin
      app_af_wren  <= af_re;
      app_wdf_wren <= wb_re;
      if (af_re) begin
        app_af_cmd  <= w_issue_rd ? MIG_CMD_RD : MIG_CMD_WR;
        app_af_addr <= af_addr;
      end
      if (wb_re) app_wdf_data <= wb_data;

      case (r_state)
        ST_INIT: if (init_done)  r_state <= ST_IDLE;
        ST_IDLE: if (w_issue_wr) r_state <= ST_WR1;
        ST_WR1:  if (w_wr_beat1) r_state <= ST_IDLE;
        default:                 r_state <= ST_INIT;
      endcase

      if (rd_data_valid) r_beat <= ~r_beat;
      if (w_issue_rd && !w_rd_done)      r_outst <= r_outst + c_OUT_W'(1);
      else if (!w_issue_rd && w_rd_done) r_outst <= r_outst - c_OUT_W'(1);

      if (w_overflow || w_unexpected) rd_err <= 1'b1;
    end
  end

  mig_rdbuf #(
    .DEPTH  (RB_DEPTH),
    .DATA_W (DATA_W)
  ) u_rdbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rd_data_valid),
    .wr_data (rd_data_fifo_out),
    .rd_en   (rb_re),
    .empty   (rb_empty),
    .full    (w_rb_full),
    .count   (w_rb_count),
    .rd_data (rb_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_mig_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mig_cmd_sequencer                                         |
// | Description : Directed bench with a queue-level reference model.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_mig_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         init_done;
  logic         af_empty;
  logic [30:0]  af_addr;
  logic         af_we;
  logic         af_re;
  logic         wb_empty;
  logic [127:0] wb_data;
  logic         wb_re;
  logic         app_af_afull;
  logic         app_wdf_afull;
  logic         app_af_wren;
  logic [2:0]   app_af_cmd;
  logic [30:0]  app_af_addr;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask_data;
  logic         rd_data_valid;
  logic [127:0] rd_data_fifo_out;
  logic         rb_re;
  logic         rb_empty;
  logic [127:0] rb_data;
  logic         rd_err;

  mig_cmd_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .init_done         (init_done),
    .af_empty          (af_empty),
    .af_addr           (af_addr),
    .af_we             (af_we),
    .af_re             (af_re),
    .wb_empty          (wb_empty),
    .wb_data           (wb_data),
    .wb_re             (wb_re),
    .app_af_afull      (app_af_afull),
    .app_wdf_afull     (app_wdf_afull),
    .app_af_wren       (app_af_wren),
    .app_af_cmd        (app_af_cmd),
    .app_af_addr       (app_af_addr),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask_data (app_wdf_mask_data),
    .rd_data_valid     (rd_data_valid),
    .rd_data_fifo_out  (rd_data_fifo_out),
    .rb_re             (rb_re),
    .rb_empty          (rb_empty),
    .rb_data           (rb_data),
    .rd_err            (rd_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_rd = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench-side FWFT FIFOs feeding the DUT
  logic [31:0]  af_q[$];
  logic [127:0] wb_q[$];
  logic         cap_af_re = 1'b0;
  logic         cap_wb_re = 1'b0;

  task automatic refresh();
    logic [31:0] t;
    af_empty = (af_q.size() == 0);
    if (af_q.size() > 0) begin
      t = af_q[0];
      af_we   = t[31];
      af_addr = t[30:0];
    end
    wb_empty = (wb_q.size() == 0);
    if (wb_q.size() > 0) wb_data = wb_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cap_af_re && af_q.size() > 0) void'(af_q.pop_front());
    if (cap_wb_re && wb_q.size() > 0) void'(wb_q.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    af_q.delete();
    wb_q.delete();
    rd_data_valid = 1'b0;
    rb_re = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: pending-write flag, read credits and a beat queue
  bit           m_ready, m_wr1, m_beat, m_err;
  int           m_outst;
  logic [127:0] rbq[$];
  logic         e_af_wren, e_wdf_wren;
  logic [2:0]   e_cmd;
  logic [30:0]  e_addr;
  logic [127:0] e_wdf_data;

  always @(negedge clk) begin
    bit x_wr, x_rd, x_w2, pop, comp;
    int sz;
    if (!rst_n) begin
      m_ready = 0; m_wr1 = 0; m_beat = 0; m_err = 0; m_outst = 0;
      rbq.delete();
      e_af_wren = 0; e_wdf_wren = 0; e_cmd = 3'b000; e_addr = '0; e_wdf_data = '0;
      cap_af_re = 0; cap_wb_re = 0;
      chk("rst_app_af_wren", app_af_wren, 0);
      chk("rst_app_wdf_wren", app_wdf_wren, 0);
      chk("rst_app_af_addr", app_af_addr, 0);
      chk("rst_rb_empty", rb_empty, 1);
      chk("rst_rd_err", rd_err, 0);
    end else begin
      sz   = rbq.size();
      x_wr = m_ready && !m_wr1 && !af_empty && af_we && !wb_empty && !app_af_afull && !app_wdf_afull;
      x_rd = m_ready && !m_wr1 && !af_empty && !af_we && !app_af_afull &&
             (m_outst < 8) && (16 - sz - 2 * m_outst >= 2);
      x_w2 = m_ready && m_wr1 && !wb_empty && !app_wdf_afull;

      chk("af_re", af_re, x_wr | x_rd);
      chk("wb_re", wb_re, x_wr | x_w2);
      chk("app_af_wren", app_af_wren, e_af_wren);
      if (e_af_wren) begin
        chk("app_af_cmd", app_af_cmd, e_cmd);
        chk("app_af_addr", app_af_addr, e_addr);
      end
      chk("app_wdf_wren", app_wdf_wren, e_wdf_wren);
      if (e_wdf_wren) chk("app_wdf_data", app_wdf_data, e_wdf_data);
      chk("mask", app_wdf_mask_data, 0);
      chk("rb_empty", rb_empty, sz == 0);
      if (sz > 0) chk("rb_data", rb_data, rbq[0]);
      chk("rd_err", rd_err, m_err);

      if (app_af_wren && app_af_cmd == 3'b001) cnt_rd++;
      cap_af_re = af_re;
      cap_wb_re = wb_re;

      e_af_wren  = x_wr | x_rd;
      if (x_wr | x_rd) begin
        e_cmd  = x_rd ? 3'b001 : 3'b000;
        e_addr = af_addr;
      end
      e_wdf_wren = x_wr | x_w2;
      if (x_wr | x_w2) e_wdf_data = wb_data;
      if (!m_ready) m_ready = init_done;
      if (x_wr) m_wr1 = 1;
      else if (x_w2) m_wr1 = 0;

      pop  = rb_re && sz > 0;
      comp = 0;
      if (pop) void'(rbq.pop_front());
      if (rd_data_valid) begin
        if (sz == 16 && !pop) m_err = 1;
        else rbq.push_back(rd_data_fifo_out);
        if (m_outst == 0 && !m_beat) m_err = 1;
        if (m_beat && m_outst > 0) comp = 1;
        m_beat = !m_beat;
      end
      m_outst = m_outst + int'(x_rd) - int'(comp);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, n;
    rst_n = 1'b0; init_done = 1'b0; app_af_afull = 1'b0; app_wdf_afull = 1'b0;
    rd_data_valid = 1'b0; rd_data_fifo_out = '0; rb_re = 1'b0;
    af_addr = '0; af_we = 1'b0; wb_data = '0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Calibration hold, then first write A/B to 0x100
    af_q.push_back({1'b1, 31'h100});
    wb_q.push_back(128'hAAAA_0001);
    wb_q.push_back(128'hBBBB_0002);
    refresh();
    for (int i = 0; i < 50; i++) begin
      tick();
      @(negedge clk);
      chk("init_hold_af_re", af_re, 0);
      chk("init_hold_af_wren", app_af_wren, 0);
    end
    tick(); init_done = 1'b1;
    @(negedge clk); chk("init_edge_af_re", af_re, 0);
    tick();
    @(negedge clk); chk("wr_af_re", af_re, 1); chk("wr_wb_re", wb_re, 1);
    tick();
    @(negedge clk);
    chk("wr_cmd_strobe", app_af_wren, 1);
    chk("wr_cmd", app_af_cmd, 3'b000);
    chk("wr_addr", app_af_addr, 31'h100);
    chk("wr_beat0", app_wdf_data, 128'hAAAA_0001);
    chk("wr_mask", app_wdf_mask_data, 0);
    tick();
    @(negedge clk);
    chk("wr_beat1_wren", app_wdf_wren, 1);
    chk("wr_beat1", app_wdf_data, 128'hBBBB_0002);
    chk("wr_beat1_no_cmd", app_af_wren, 0);

    // Write with second beat late; init_done dropping must be ignored
    init_done = 1'b0;
    tick();
    af_q.push_back({1'b1, 31'h200});
    wb_q.push_back(128'hA2);
    refresh();
    @(negedge clk); chk("wr2_af_re", af_re, 1);
    tick(); @(negedge clk); chk("wr2_beat0", app_wdf_data, 128'hA2);
    for (int i = 0; i < 2; i++) begin
      tick(); @(negedge clk);
      chk("wr2_stall_wdf", app_wdf_wren, 0);
      chk("wr2_stall_wb_re", wb_re, 0);
    end
    tick(); wb_q.push_back(128'hB2); refresh();
    @(negedge clk); chk("wr2_late_wb_re", wb_re, 1);
    tick(); @(negedge clk);
    chk("wr2_beat1_wren", app_wdf_wren, 1);
    chk("wr2_beat1", app_wdf_data, 128'hB2);

    // Ten reads with no return data: credits cap issue at eight
    tick();
    for (int i = 0; i < 10; i++) af_q.push_back({1'b0, 31'h1000 + 31'(i * 16)});
    refresh();
    n0 = cnt_rd;
    repeat (20) tick();
    @(negedge clk); chk("reads_capped", cnt_rd - n0, 8);
    tick(); rb_re = 1'b1; rd_data_valid = 1'b1; rd_data_fifo_out = 128'hD0;
    tick(); rd_data_fifo_out = 128'hD1;
    tick(); rd_data_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("read_after_credit", cnt_rd - n0, 9);
    chk("rb_drained", rb_empty, 1);

    // Reset with reads in flight, then an unexpected beat
    init_done = 1'b1;
    do_reset();
    tick(); rd_data_valid = 1'b1; rd_data_fifo_out = 128'hEE;
    tick(); rd_data_valid = 1'b0;
    @(negedge clk); chk("unexp_err", rd_err, 1);
    repeat (5) tick();
    @(negedge clk); chk("unexp_err_sticky", rd_err, 1);
    do_reset();
    @(negedge clk);
    chk("reset_clears_err", rd_err, 0);
    chk("reset_rb_empty", rb_empty, 1);

    // Fill the buffer with eight reads' data, then push and pop while full
    tick();
    for (int i = 0; i < 8; i++) af_q.push_back({1'b0, 31'h2000 + 31'(i * 16)});
    refresh();
    repeat (12) tick();
    for (int i = 0; i < 16; i++) begin
      tick(); rd_data_valid = 1'b1; rd_data_fifo_out = 128'hF000 + 128'(i);
    end
    tick(); rd_data_fifo_out = 128'hC0DE; rb_re = 1'b1;
    @(negedge clk);
    chk("full_no_err_yet", rd_err, 0);
    chk("full_head", rb_data, 128'hF000);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); rd_data_valid = 1'b0;
      @(negedge clk);
      if (i == 0) chk("full_head_after_pop", rb_data, 128'hF001);
      if (!rb_empty) n++;
    end
    chk("full_count_kept", n, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
